// File: rtl/alu_master.sv
// alu_master: bus initiator that owns every ALU register-file cycle.
// Accepts one command (control word plus two operands) on a valid/ready
// handshake. It writes DR0, DR1 and CR, waits SETTLE_CYCLES, reads RE and AD,
// and returns both words in a single response beat.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_cr/cmd_op0/cmd_op1 payload
//   rsp_valid/rsp_ready         response handshake; rsp_re/rsp_ad payload
//   addr_bus                    {region code, 4'h0}; region 0 selects nothing
//   data_bus_out, bus_we        write data and one-cycle write strobe
//   bus_rd, data_bus_in         read strobe and combinational read data
//   busy                        high whenever a command is in flight
module alu_master #(
  parameter int          DATA_WIDTH    = 8,
  parameter logic [3:0]  DR0_SEL       = 4'h1,
  parameter logic [3:0]  DR1_SEL       = 4'h2,
  parameter logic [3:0]  CR_SEL        = 4'h3,
  parameter logic [3:0]  RE_SEL        = 4'h4,
  parameter logic [3:0]  AD_SEL        = 4'h5,
  parameter int          SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_cr,
  input  logic [DATA_WIDTH-1:0] cmd_op0,
  input  logic [DATA_WIDTH-1:0] cmd_op1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_re,
  output logic [DATA_WIDTH-1:0] rsp_ad,
  output logic [7:0]            addr_bus,
  output logic [DATA_WIDTH-1:0] data_bus_out,
  output logic                  bus_we,
  output logic                  bus_rd,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  output logic                  busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_DR0, ST_WR_DR1, ST_WR_CR, ST_WAIT, ST_RD_RE, ST_RD_AD, ST_RESP
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] cr;
    logic [DATA_WIDTH-1:0] op0;
    logic [DATA_WIDTH-1:0] op1;
  } cmd_t;

  // WAIT counts down to zero, so it is loaded with one less than the settle time.
  localparam logic [3:0] SETTLE_M1 = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  cmd_t       cmd_q;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cmd_q  <= '0;
      cnt    <= '0;
      rsp_re <= '0;
      rsp_ad <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_valid && cmd_ready)
        cmd_q <= '{cr: cmd_cr, op0: cmd_op0, op1: cmd_op1};
      if (state == ST_WR_CR)
        cnt <= SETTLE_M1;
      else if (state == ST_WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (state == ST_RD_RE) rsp_re <= data_bus_in;
      if (state == ST_RD_AD) rsp_ad <= data_bus_in;
    end
  end

  // Bus outputs decode straight from state, so an async reset idles the bus
  // in the same instant it clears the state register.
  always_comb begin
    state_nxt    = state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    addr_bus     = 8'h00;
    data_bus_out = '0;
    bus_we       = 1'b0;
    bus_rd       = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_WR_DR0;
      end
      ST_WR_DR0: begin
        addr_bus     = {DR0_SEL, 4'h0};
        data_bus_out = cmd_q.op0;
        bus_we       = 1'b1;
        state_nxt    = ST_WR_DR1;
      end
      ST_WR_DR1: begin
        addr_bus     = {DR1_SEL, 4'h0};
        data_bus_out = cmd_q.op1;
        bus_we       = 1'b1;
        state_nxt    = ST_WR_CR;
      end
      ST_WR_CR: begin
        addr_bus     = {CR_SEL, 4'h0};
        data_bus_out = cmd_q.cr;
        bus_we       = 1'b1;
        state_nxt    = (SETTLE_CYCLES == 0) ? ST_RD_RE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == 4'd0) state_nxt = ST_RD_RE;
      end
      ST_RD_RE: begin
        addr_bus  = {RE_SEL, 4'h0};
        bus_rd    = 1'b1;
        state_nxt = ST_RD_AD;
      end
      ST_RD_AD: begin
        addr_bus  = {AD_SEL, 4'h0};
        bus_rd    = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_master.sv
// Bench for alu_master. There are three instances with SETTLE_CYCLES = 1, 0
// and 4. They share the command and response inputs, and each one has its own
// small ALU model on its bus. Expected responses for instance 0 are queued
// when a command is accepted, and they are popped when the response arrives.
module tb_alu_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic rsp_ready = 1'b1;
  logic [7:0] cmd_cr = '0, cmd_op0 = '0, cmd_op1 = '0;

  logic       cmd_ready [3];
  logic       rsp_valid [3];
  logic [7:0] rsp_re [3];
  logic [7:0] rsp_ad [3];
  logic [7:0] addr_bus [3];
  logic [7:0] data_bus_out [3];
  logic       bus_we [3];
  logic       bus_rd [3];
  logic [7:0] data_bus_in [3];
  logic       busy [3];

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {logic [7:0] re; logic [7:0] ad;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] f_re(logic [7:0] cr, logic [7:0] a, logic [7:0] b);
    logic [7:0] s;
    s = a + b;
    return s ^ (cr & 8'hF0);
  endfunction
  function automatic logic [7:0] f_ad(logic [7:0] cr, logic [7:0] a, logic [7:0] b);
    return a & b & cr;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 0) ? 1 : (g == 1) ? 0 : 4;
    logic [7:0] dr0 = '0, dr1 = '0, crr = '0;
    alu_master #(.SETTLE_CYCLES(S)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[g]),
      .cmd_cr(cmd_cr), .cmd_op0(cmd_op0), .cmd_op1(cmd_op1),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready),
      .rsp_re(rsp_re[g]), .rsp_ad(rsp_ad[g]),
      .addr_bus(addr_bus[g]), .data_bus_out(data_bus_out[g]),
      .bus_we(bus_we[g]), .bus_rd(bus_rd[g]),
      .data_bus_in(data_bus_in[g]), .busy(busy[g])
    );
    // The ALU register file model: write registers, then read results combinationally.
    always @(posedge clk)
      if (bus_we[g])
        case (addr_bus[g])
          8'h10: dr0 <= data_bus_out[g];
          8'h20: dr1 <= data_bus_out[g];
          8'h30: crr <= data_bus_out[g];
          default: ;
        endcase
    assign data_bus_in[g] = !bus_rd[g] ? 8'hEE :
                            (addr_bus[g] == 8'h40) ? f_re(crr, dr0, dr1) :
                            (addr_bus[g] == 8'h50) ? f_ad(crr, dr0, dr1) : 8'hEE;
  end

  // Scoreboard push for instance 0 at the accepting edge.
  always @(posedge clk)
    if (rst_n && cmd_valid && cmd_ready[0])
      sb.push_back('{re: f_re(cmd_cr, cmd_op0, cmd_op1), ad: f_ad(cmd_cr, cmd_op0, cmd_op1)});

  // Waits on negedges until instance 0 shows rsp_valid, within a fixed bound.
  task automatic wait_rsp0(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      if (rsp_valid[0]) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic drive_cmd(input logic [7:0] cr, input logic [7:0] a, input logic [7:0] b);
    cmd_cr = cr; cmd_op0 = a; cmd_op1 = b; cmd_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'($urandom); rsp_ready = 1'($urandom);
      cmd_cr = 8'($urandom); cmd_op0 = 8'($urandom); cmd_op1 = 8'($urandom);
      @(negedge clk);
    end
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({cmd_ready[g], rsp_valid[g], rsp_re[g], rsp_ad[g], addr_bus[g], data_bus_out[g],
           bus_we[g], bus_rd[g], busy[g]} !== {1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: rdy=%b vld=%b re=%h ad=%h addr=%h do=%h we=%b rd=%b busy=%b, need rdy=1 rest 0",
                 g, cmd_ready[g], rsp_valid[g], rsp_re[g], rsp_ad[g], addr_bus[g], data_bus_out[g], bus_we[g], bus_rd[g], busy[g]);
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({cmd_ready[0], busy[0], addr_bus[0], bus_we[0], bus_rd[0]} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b busy=%b addr=%h we=%b rd=%b, need 1 0 00 0 0",
               cmd_ready[0], busy[0], addr_bus[0], bus_we[0], bus_rd[0]);
    end
  endtask

  task automatic test_single;
    // Expected bus trace for S=1, per negedge after acceptance: {addr, data, we, rd}.
    logic [17:0] trace [6];
    trace[0] = {8'h10, 8'h12, 2'b10};
    trace[1] = {8'h20, 8'h34, 2'b10};
    trace[2] = {8'h30, 8'h05, 2'b10};
    trace[3] = {8'h00, 8'h00, 2'b00};
    trace[4] = {8'h40, 8'h00, 2'b01};
    trace[5] = {8'h50, 8'h00, 2'b01};
    drive_cmd(8'h05, 8'h12, 8'h34);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_cr = 8'hFF; cmd_op0 = 8'hFF; cmd_op1 = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({addr_bus[0], data_bus_out[0], bus_we[0], bus_rd[0]} !== trace[k] || rsp_valid[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL single_bus cyc%0d: addr=%h do=%h we=%b rd=%b vld=%b, need %h", k + 1,
                 addr_bus[0], data_bus_out[0], bus_we[0], bus_rd[0], rsp_valid[0], trace[k]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_re[0] !== 8'h46 || rsp_ad[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL single_rsp: vld=%b re=%h ad=%h, need 1 46 00", rsp_valid[0], rsp_re[0], rsp_ad[0]);
    end
    n_checks++;
    if (sb.size() != 1 || rsp_re[0] !== sb[0].re || rsp_ad[0] !== sb[0].ad) begin
      n_fail++;
      $display("FAIL single_sb: size=%0d re=%h ad=%h", sb.size(), rsp_re[0], rsp_ad[0]);
    end
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    n_checks++;
    if (cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: rdy=%b busy=%b, need 1 0", cmd_ready[0], busy[0]);
    end
  endtask

  task automatic test_backpressure;
    bit got;
    bit bad = 1'b0;
    exp_t e;
    rsp_ready = 1'b0;
    drive_cmd(8'h9C, 8'h3B, 8'h71);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp0(20, got);
    n_checks++;
    if (!got || sb.size() == 0) begin
      n_fail++;
      $display("FAIL bp_timeout: rsp_valid=%b sb=%0d, need 1 and 1", rsp_valid[0], sb.size());
      rsp_ready = 1'b1;
      sb.delete();
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid[0] !== 1'b1 || rsp_re[0] !== e.re || rsp_ad[0] !== e.ad || cmd_ready[0] !== 1'b0 ||
          addr_bus[0] !== 8'h00 || bus_we[0] !== 1'b0 || bus_rd[0] !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: vld=%b re=%h ad=%h rdy=%b addr=%h, need 1 %h %h 0 00",
               rsp_valid[0], rsp_re[0], rsp_ad[0], cmd_ready[0], addr_bus[0], e.re, e.ad);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b, need 0 1 0", rsp_valid[0], cmd_ready[0], busy[0]);
    end
  endtask

  task automatic test_settle;
    int cr_k [3];
    int re_k [3];
    bit got [3];
    logic [7:0] gre [3];
    logic [7:0] gad [3];
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int g = 0; g < 3; g++) begin cr_k[g] = -1; re_k[g] = -1; got[g] = 1'b0; end
    drive_cmd(8'hA3, 8'h07, 8'h09);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (bus_we[g] && addr_bus[g] == 8'h30) cr_k[g] = k;
        if (bus_rd[g] && addr_bus[g] == 8'h40) re_k[g] = k;
        if (rsp_valid[g] && !got[g]) begin got[g] = 1'b1; gre[g] = rsp_re[g]; gad[g] = rsp_ad[g]; end
      end
    end
    for (int g = 0; g < 3; g++) begin
      int s;
      s = (g == 0) ? 1 : (g == 1) ? 0 : 4;
      n_checks++;
      if (cr_k[g] != 3 || re_k[g] - cr_k[g] - 1 != s) begin
        n_fail++;
        $display("FAIL settle_gap inst%0d: cr_cyc=%0d re_cyc=%0d, need 3 and %0d", g, cr_k[g], re_k[g], 4 + s);
      end
      n_checks++;
      if (!got[g] || gre[g] !== f_re(8'hA3, 8'h07, 8'h09) || gad[g] !== f_ad(8'hA3, 8'h07, 8'h09)) begin
        n_fail++;
        $display("FAIL settle_rsp inst%0d: got=%b re=%h ad=%h, need 1 %h %h", g, got[g], gre[g], gad[g],
                 f_re(8'hA3, 8'h07, 8'h09), f_ad(8'hA3, 8'h07, 8'h09));
      end
    end
    sb.delete();
  endtask

  task automatic test_reset_in_wait;
    bit bad = 1'b0;
    bit got;
    exp_t e;
    drive_cmd(8'h11, 8'h22, 8'h33);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    // Now in WAIT (S=1); pull reset asynchronously.
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy[0] !== 1'b0 || addr_bus[0] !== 8'h00 || bus_we[0] !== 1'b0 || cmd_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: busy=%b addr=%h we=%b rdy=%b, need 0 00 0 1", busy[0], addr_bus[0], bus_we[0], cmd_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      if (bus_rd[0] || bus_we[0] || rsp_valid[0]) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_drop: bus or response activity after reset, need none");
    end
    drive_cmd(8'h60, 8'h0F, 8'hF1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp0(20, got);
    n_checks++;
    if (!got || sb.size() != 1) begin
      n_fail++;
      $display("FAIL rst_next_timeout: got=%b sb=%0d, need 1 1", got, sb.size());
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_re[0] !== e.re || rsp_ad[0] !== e.ad) begin
        n_fail++;
        $display("FAIL rst_next_rsp: re=%h ad=%h, need %h %h", rsp_re[0], rsp_ad[0], e.re, e.ad);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit got;
    exp_t e;
    bit early = 1'b0;
    drive_cmd(8'h40, 8'h55, 8'h0A);
    @(negedge clk);
    // First command is in flight; present the second one and keep valid high.
    drive_cmd(8'h8F, 8'hC3, 8'h3C);
    for (int k = 1; k < 7; k++) begin
      if (cmd_ready[0] !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (early || sb.size() != 1) begin
      n_fail++;
      $display("FAIL b2b_overlap: early_ready=%b sb=%0d, need 0 1", early, sb.size());
    end
    n_checks++;
    if (rsp_valid[0] !== 1'b1 || sb.size() == 0 || rsp_re[0] !== sb[0].re || rsp_ad[0] !== sb[0].ad) begin
      n_fail++;
      $display("FAIL b2b_rsp1: vld=%b re=%h ad=%h, need 1 %h %h", rsp_valid[0], rsp_re[0], rsp_ad[0],
               f_re(8'h40, 8'h55, 8'h0A), f_ad(8'h40, 8'h55, 8'h0A));
    end
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    n_checks++;
    if (cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: rdy=%b busy=%b, need 1 0", cmd_ready[0], busy[0]);
    end
    @(negedge clk);
    drive_cmd(8'h00, 8'h00, 8'h00);
    cmd_valid = 1'b0;
    n_checks++;
    if (bus_we[0] !== 1'b1 || addr_bus[0] !== 8'h10 || data_bus_out[0] !== 8'hC3) begin
      n_fail++;
      $display("FAIL b2b_start2: we=%b addr=%h do=%h, need 1 10 c3", bus_we[0], addr_bus[0], data_bus_out[0]);
    end
    wait_rsp0(20, got);
    n_checks++;
    if (!got || sb.size() != 1) begin
      n_fail++;
      $display("FAIL b2b_timeout2: got=%b sb=%0d, need 1 1", got, sb.size());
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (rsp_re[0] !== e.re || rsp_ad[0] !== e.ad) begin
        n_fail++;
        $display("FAIL b2b_rsp2: re=%h ad=%h, need %h %h", rsp_re[0], rsp_ad[0], e.re, e.ad);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_settle();
    test_reset_in_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
